// File: rtl/tri_feeder_if.sv
// Triangle feeder bus: upstream triangle handshake, rasterizer
// vertex/point signals and the captured per-triangle results.
interface tri_feeder_if;
    logic        tri_valid;
    logic        tri_ready;
    logic [17:0] tri_data;
    logic        nt;
    logic [2:0]  xi;
    logic [2:0]  yi;
    logic        busy;
    logic        po;
    logic [2:0]  xo;
    logic [2:0]  yo;
    logic [63:0] bitmap;
    logic [6:0]  pix_cnt;
    logic        dup_err;
    logic        timeout;
    logic        frame_done;

    modport slave (
        input  tri_valid, tri_data, busy, po, xo, yo,
        output tri_ready, nt, xi, yi, bitmap, pix_cnt,
               dup_err, timeout, frame_done
    );

    modport master (
        output tri_valid, tri_data, busy, po, xo, yo,
        input  tri_ready, nt, xi, yi, bitmap, pix_cnt,
               dup_err, timeout, frame_done
    );
endinterface

// File: rtl/tri_feeder.sv
// Feeds one triangle's vertices to a rasterizer, then collects the
// rasterized points into a 8x8 bitmap with duplicate/timeout flags.
module tri_feeder #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic         clk,
    input logic         reset,
    tri_feeder_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, SEND1, SEND2, SEND3, COLLECT, DONE
    } state_t;

    state_t      state;
    logic [17:0] vtx;
    logic [7:0]  timer;
    logic        saw_busy;
    logic [63:0] bitmap;
    logic [6:0]  pix_cnt;
    logic        dup_err;
    logic        timeout;
    logic        frame_done;
    logic        nt;
    logic [2:0]  xi;
    logic [2:0]  yi;

    logic [5:0]  idx;
    logic        fin_busy;
    logic        fin_tmo;

    assign idx      = {bus.yo, bus.xo};
    // saw_busy is the registered history, so a busy=0 in the very
    // cycle busy first rises cannot end the frame.
    assign fin_busy = saw_busy & ~bus.busy;
    assign fin_tmo  = (timer == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            vtx        <= '0;
            timer      <= '0;
            saw_busy   <= 1'b0;
            bitmap     <= '0;
            pix_cnt    <= '0;
            dup_err    <= 1'b0;
            timeout    <= 1'b0;
            frame_done <= 1'b0;
            nt         <= 1'b0;
            xi         <= '0;
            yi         <= '0;
        end else begin
            nt         <= 1'b0;
            xi         <= '0;
            yi         <= '0;
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.tri_valid) begin
                        vtx      <= bus.tri_data;
                        bitmap   <= '0;
                        pix_cnt  <= '0;
                        dup_err  <= 1'b0;
                        timeout  <= 1'b0;
                        saw_busy <= 1'b0;
                        timer    <= '0;
                        nt       <= 1'b1;
                        xi       <= bus.tri_data[17:15];
                        yi       <= bus.tri_data[14:12];
                        state    <= SEND1;
                    end
                end
                SEND1: begin
                    xi       <= vtx[11:9];
                    yi       <= vtx[8:6];
                    saw_busy <= saw_busy | bus.busy;
                    state    <= SEND2;
                end
                SEND2: begin
                    xi       <= vtx[5:3];
                    yi       <= vtx[2:0];
                    saw_busy <= saw_busy | bus.busy;
                    state    <= SEND3;
                end
                SEND3: begin
                    saw_busy <= saw_busy | bus.busy;
                    state    <= COLLECT;
                end
                COLLECT: begin
                    if (bus.po) begin
                        if (bitmap[idx]) begin
                            dup_err <= 1'b1;
                        end else begin
                            bitmap[idx] <= 1'b1;
                            pix_cnt     <= pix_cnt + 7'd1;
                        end
                    end
                    saw_busy <= saw_busy | bus.busy;
                    if (fin_busy) begin
                        frame_done <= 1'b1;
                        state      <= DONE;
                    end else if (fin_tmo) begin
                        timeout    <= 1'b1;
                        frame_done <= 1'b1;
                        state      <= DONE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tri_ready  = (state == IDLE);
    assign bus.nt         = nt;
    assign bus.xi         = xi;
    assign bus.yi         = yi;
    assign bus.bitmap     = bitmap;
    assign bus.pix_cnt    = pix_cnt;
    assign bus.dup_err    = dup_err;
    assign bus.timeout    = timeout;
    assign bus.frame_done = frame_done;
endmodule

// File: tb/tb_tri_feeder.sv
// Bench for tri_feeder: directed frames plus randomized frames
// checked against a per-frame behavioural model.
module tb_tri_feeder;
    localparam int TMO = 10;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic       cb[64];
    logic       cp[64];
    logic [5:0] cpos[64];

    tri_feeder_if f();

    tri_feeder #(.TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (f.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        f.tri_valid = 1'b0;
        f.tri_data  = '0;
        f.busy      = 1'b0;
        f.po        = 1'b0;
        f.xo        = '0;
        f.yo        = '0;
    endtask

    task automatic clr;
        for (int i = 0; i < 64; i++) begin
            cb[i]   = 1'b0;
            cp[i]   = 1'b0;
            cpos[i] = '0;
        end
    endtask

    function automatic logic [5:0] pos(input int x, input int y);
        return {3'(y), 3'(x)};
    endfunction

    // sb[v] is busy while vertex v+1 is on the bus; cb/cp/cpos give
    // busy/po/point for each cycle after the last vertex.
    task automatic run_frame(input logic [17:0] d, input logic [2:0] sb);
        logic [63:0] eb;
        int          ec;
        int          ex;
        bit          ed;
        bit          et;
        bit          saw;
        bit          fin;
        logic [2:0]  vx;
        logic [2:0]  vy;
        eb  = '0;
        ec  = 0;
        ed  = 0;
        et  = 0;
        ex  = 0;
        fin = 0;
        saw = |sb;
        for (int c = 0; c < TMO && !fin; c++) begin
            if (cp[c]) begin
                if (eb[cpos[c]]) ed = 1;
                else begin
                    eb[cpos[c]] = 1'b1;
                    ec++;
                end
            end
            if (!cb[c] && saw) fin = 1;
            else if (c == TMO - 1) begin
                fin = 1;
                et  = 1;
            end
            if (cb[c]) saw = 1;
            ex = c;
        end

        chk("ready_idle", f.tri_ready, 1);
        f.tri_valid = 1'b1;
        f.tri_data  = d;
        step();
        f.tri_valid = 1'b0;
        f.tri_data  = 18'($urandom);
        for (int v = 0; v < 3; v++) begin
            vx = d[17-6*v -: 3];
            vy = d[14-6*v -: 3];
            chk("nt", f.nt, (v == 0) ? 1 : 0);
            chk("xi", f.xi, vx);
            chk("yi", f.yi, vy);
            chk("ready_send", f.tri_ready, 0);
            f.busy = sb[v];
            f.po   = 1'($urandom);
            {f.yo, f.xo} = 6'($urandom);
            step();
        end
        for (int c = 0; c <= ex; c++) begin
            f.busy      = cb[c];
            f.po        = cp[c];
            {f.yo, f.xo} = cpos[c];
            f.tri_valid = 1'($urandom);
            chk("nt_coll", f.nt, 0);
            chk("xi_coll", f.xi, 0);
            chk("ready_coll", f.tri_ready, 0);
            step();
            if (c < ex) chk("fd_early", f.frame_done, 0);
        end
        chk("fd", f.frame_done, 1);
        chk("bitmap", f.bitmap, eb);
        chk("pix_cnt", f.pix_cnt, 64'(ec));
        chk("dup_err", f.dup_err, 64'(ed));
        chk("timeout", f.timeout, 64'(et));
        chk("ready_done", f.tri_ready, 0);
        f.busy      = 1'b0;
        f.tri_valid = 1'b1;
        f.po        = 1'b1;
        {f.yo, f.xo} = 6'($urandom);
        step();
        idle_in();
        chk("fd_pulse", f.frame_done, 0);
        chk("ready_after", f.tri_ready, 1);
        chk("bitmap_hold", f.bitmap, eb);
        chk("cnt_hold", f.pix_cnt, 64'(ec));
        step();
    endtask

    initial begin
        reset = 1'b1;
        idle_in();
        clr();
        #12;
        chk("rst_ready", f.tri_ready, 1);
        chk("rst_nt", f.nt, 0);
        chk("rst_xi", f.xi, 0);
        chk("rst_yi", f.yi, 0);
        chk("rst_bitmap", f.bitmap, 0);
        chk("rst_cnt", f.pix_cnt, 0);
        chk("rst_dup", f.dup_err, 0);
        chk("rst_tmo", f.timeout, 0);
        chk("rst_fd", f.frame_done, 0);
        step();
        reset = 1'b0;
        step();

        clr();
        for (int c = 0; c < 3; c++) cb[c] = 1'b1;
        cp[0] = 1'b1; cpos[0] = pos(1, 2);
        cp[1] = 1'b1; cpos[1] = pos(2, 2);
        cp[2] = 1'b1; cpos[2] = pos(1, 3);
        run_frame({3'd1, 3'd1, 3'd0, 3'd3, 3'd3, 3'd3}, 3'b100);

        clr();
        cb[0] = 1'b1; cp[0] = 1'b1; cpos[0] = pos(4, 4);
        cb[1] = 1'b1; cp[1] = 1'b1; cpos[1] = pos(4, 4);
        run_frame(18'($urandom), 3'b000);

        clr();
        run_frame(18'($urandom), 3'b000);

        clr();
        cb[0] = 1'b1;
        cp[1] = 1'b1; cpos[1] = pos(7, 7);
        run_frame(18'($urandom), 3'b000);

        clr();
        cp[0] = 1'b1; cpos[0] = pos(0, 0);
        run_frame(18'($urandom), 3'b010);

        f.tri_valid = 1'b1;
        f.tri_data  = 18'($urandom);
        step();
        f.tri_valid = 1'b0;
        step();
        reset = 1'b1;
        #1;
        chk("mid_nt", f.nt, 0);
        chk("mid_xi", f.xi, 0);
        chk("mid_yi", f.yi, 0);
        chk("mid_ready", f.tri_ready, 1);
        chk("mid_bitmap", f.bitmap, 0);
        chk("mid_cnt", f.pix_cnt, 0);
        chk("mid_fd", f.frame_done, 0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_nt", f.nt, 0);
            chk("post_ready", f.tri_ready, 1);
        end

        for (int n = 0; n < 25; n++) begin
            int len;
            clr();
            len = $urandom_range(0, 12);
            for (int c = 0; c < 64; c++) begin
                cb[c]   = (c < len) && ($urandom_range(0, 3) != 0);
                cp[c]   = 1'($urandom);
                cpos[c] = 6'($urandom_range(0, 15));
            end
            run_frame(18'($urandom), 3'($urandom));
            for (int i = $urandom_range(0, 2); i > 0; i--) begin
                f.po = 1'($urandom);
                {f.yo, f.xo} = 6'($urandom);
                step();
            end
            idle_in();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
